// File: rtl/unidad_procesadora.sv
// Purpose : 4-bit datapath with an 8 x 4-bit register file, a function unit and flag generation,
//           all steered by one 16-bit control word.
// Latency : reads, function unit and flags are combinational; a register write lands on the next
//           rising edge, so a dependent read is valid one cycle later.
// Backpressure : none; a control word is consumed every cycle.
// Ports   : clk, rst (sync, active-high) | control[15:0] = {DA,AA,BA,MB,FS,MD,RW}
//           datain, Constant_IN (4b) in | flags = {V,C,N,Z}, dataout = B bus, adr_out = A bus
module unidad_procesadora (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] control,
  input  logic [3:0]  datain,
  input  logic [3:0]  Constant_IN,
  output logic [3:0]  flags,
  output logic [3:0]  dataout,
  output logic [3:0]  adr_out
);

  // Control word fields
  logic [2:0] da, aa, ba;
  logic       mb, md, rw;
  logic [3:0] fs;

  assign da = control[15:13];
  assign aa = control[12:10];
  assign ba = control[9:7];
  assign mb = control[6];
  assign fs = control[5:2];
  assign md = control[1];
  assign rw = control[0];

  logic [3:0] regs [8];
  logic [3:0] a_bus, b_reg, b_bus, d_bus;
  logic [3:0] f;
  logic       c_flag, v_flag;

  // Adder operands: the arithmetic half of the FS map is always A plus some addend plus carry-in
  logic [3:0] add_y;
  logic       add_cin;
  logic [4:0] sum;

  assign a_bus   = regs[aa];
  assign b_reg   = regs[ba];
  assign b_bus   = mb ? Constant_IN : b_reg;
  assign adr_out = a_bus;
  assign dataout = b_bus;

  always_comb begin
    add_y   = 4'b0000;
    add_cin = 1'b0;
    case (fs[2:0])
      3'b001:  add_y = 4'b0001;
      3'b010:  add_y = b_bus;
      3'b011:  begin add_y = b_bus;  add_cin = 1'b1; end
      3'b100:  add_y = ~b_bus;
      3'b101:  begin add_y = ~b_bus; add_cin = 1'b1; end
      3'b110:  add_y = 4'b1111;
      default: add_y = 4'b0000;   // 000 and 111 pass A through the adder
    endcase
    sum = {1'b0, a_bus} + {1'b0, add_y} + {4'b0000, add_cin};
  end

  always_comb begin
    f      = sum[3:0];
    c_flag = sum[4];
    // Overflow: addends agree in sign but the result does not
    v_flag = (a_bus[3] == add_y[3]) && (sum[3] != a_bus[3]);
    if (fs[3]) begin
      c_flag = 1'b0;
      v_flag = 1'b0;
      case (fs[2:0])
        3'b000:  f = a_bus & b_bus;
        3'b001:  f = a_bus | b_bus;
        3'b010:  f = a_bus ^ b_bus;
        3'b011:  f = ~a_bus;
        3'b100:  f = b_bus;
        3'b101:  begin f = {1'b0, b_bus[3:1]}; c_flag = b_bus[0]; end
        3'b110:  begin f = {b_bus[2:0], 1'b0}; c_flag = b_bus[3]; end
        default: f = b_bus;
      endcase
    end
  end

  assign flags = {v_flag, c_flag, f[3], (f == 4'b0000)};
  assign d_bus = md ? datain : f;

  // Reset wins over a pending write in the same cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 8; i++) regs[i] <= 4'b0000;
    end else if (rw) begin
      regs[da] <= d_bus;
    end
  end

endmodule

// File: tb/tb_unidad_procesadora.sv
module tb_unidad_procesadora;
  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] control;
  logic [3:0]  datain, Constant_IN;
  logic [3:0]  flags, dataout, adr_out;

  int checks = 0;
  int errors = 0;
  int mreg [8];

  always #5 clk = ~clk;

  unidad_procesadora dut (
    .clk(clk), .rst(rst), .control(control), .datain(datain),
    .Constant_IN(Constant_IN), .flags(flags), .dataout(dataout), .adr_out(adr_out)
  );

  function automatic logic [15:0] mk(input int da, input int aa, input int ba, input int mb,
                                     input int fs, input int md, input int rw);
    logic [15:0] w;
    w = {da[2:0], aa[2:0], ba[2:0], mb[0], fs[3:0], md[0], rw[0]};
    return w;
  endfunction

  // Reference: plain integer arithmetic; V taken as the signed result leaving [-8,7]
  function automatic void ref_alu(input int fs, input int a, input int b,
                                  output int f, output int fl);
    int y, ci, sum, sa, sy, ss, v, c;
    y = 0; ci = 0; v = 0; c = 0; f = 0;
    if (fs < 8) begin
      case (fs)
        1: y = 1;
        2: y = b;
        3: begin y = b; ci = 1; end
        4: y = 15 - b;
        5: begin y = 15 - b; ci = 1; end
        6: y = 15;
        default: y = 0;
      endcase
      sum = a + y + ci;
      f = sum % 16;
      c = (sum > 15) ? 1 : 0;
      sa = (a > 7) ? a - 16 : a;
      sy = (y > 7) ? y - 16 : y;
      ss = sa + sy + ci;
      v = (ss > 7 || ss < -8) ? 1 : 0;
    end else begin
      case (fs)
        8:  f = a & b;
        9:  f = a | b;
        10: f = a ^ b;
        11: f = 15 - a;
        12: f = b;
        13: begin f = b / 2; c = b % 2; end
        14: begin f = (b * 2) % 16; c = (b >= 8) ? 1 : 0; end
        default: f = b;
      endcase
    end
    fl = v * 8 + c * 4 + ((f >= 8) ? 2 : 0) + ((f == 0) ? 1 : 0);
  endfunction

  task automatic drive(input logic r, input logic [15:0] c, input logic [3:0] di, input logic [3:0] k);
    rst = r; control = c; datain = di; Constant_IN = k;
    #1;
  endtask

  // Advance one clock edge, updating the model with whatever the bench is currently driving
  task automatic step();
    int a, b, f, fl;
    a = mreg[control[12:10]];
    b = control[6] ? int'(Constant_IN) : mreg[control[9:7]];
    ref_alu(int'(control[5:2]), a, b, f, fl);
    if (rst) begin
      for (int i = 0; i < 8; i++) mreg[i] = 0;
    end else if (control[0]) begin
      mreg[control[15:13]] = control[1] ? int'(datain) : f;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    drive(1'b1, 16'h0000, 4'h0, 4'h0);
    step();
    step();
    drive(1'b0, 16'h0000, 4'h0, 4'h0);
    checks++; if (adr_out !== 4'b0000) begin errors++; $display("FAIL reset_adr_out: got %b expected 0000", adr_out); end
    checks++; if (dataout !== 4'b0000) begin errors++; $display("FAIL reset_dataout: got %b expected 0000", dataout); end
    checks++; if (flags !== 4'b0001) begin errors++; $display("FAIL reset_flags: got %b expected 0001", flags); end
    for (int i = 0; i < 8; i++) begin
      drive(1'b0, mk(0, i, i, 0, 0, 0, 0), 4'h0, 4'h0);
      checks++; if (adr_out !== 4'b0000) begin errors++; $display("FAIL reset_regA R%0d: got %b expected 0000", i, adr_out); end
      checks++; if (dataout !== 4'b0000) begin errors++; $display("FAIL reset_regB R%0d: got %b expected 0000", i, dataout); end
    end
  endtask

  task automatic test_load();
    drive(1'b0, 16'h2003, 4'b0101, 4'h0);
    step();
    drive(1'b0, mk(0, 1, 0, 0, 0, 0, 0), 4'h0, 4'h0);
    checks++; if (adr_out !== 4'b0101) begin errors++; $display("FAIL load_r1: got %b expected 0101", adr_out); end
  endtask

  task automatic test_add_const();
    drive(1'b0, 16'h4449, 4'h0, 4'b0011);
    checks++; if (flags !== 4'b1010) begin errors++; $display("FAIL add_flags: got %b expected 1010", flags); end
    checks++; if (dataout !== 4'b0011) begin errors++; $display("FAIL add_dataout: got %b expected 0011", dataout); end
    step();
    drive(1'b0, mk(0, 2, 0, 0, 0, 0, 0), 4'h0, 4'h0);
    checks++; if (adr_out !== 4'b1000) begin errors++; $display("FAIL add_r2: got %b expected 1000", adr_out); end
  endtask

  task automatic test_sub();
    drive(1'b0, 16'h6495, 4'h0, 4'h0);
    checks++; if (adr_out !== 4'b0101) begin errors++; $display("FAIL sub_adr_out: got %b expected 0101", adr_out); end
    checks++; if (dataout !== 4'b0101) begin errors++; $display("FAIL sub_dataout: got %b expected 0101", dataout); end
    checks++; if (flags !== 4'b0101) begin errors++; $display("FAIL sub_flags: got %b expected 0101", flags); end
    step();
    drive(1'b0, mk(0, 3, 0, 0, 0, 0, 0), 4'h0, 4'h0);
    checks++; if (adr_out !== 4'b0000) begin errors++; $display("FAIL sub_r3: got %b expected 0000", adr_out); end
  endtask

  task automatic test_shift();
    drive(1'b0, mk(5, 0, 0, 0, 0, 1, 1), 4'b1010, 4'h0);
    step();
    drive(1'b0, mk(4, 0, 0, 1, 13, 0, 1), 4'h0, 4'b1001);
    checks++; if (flags !== 4'b0100) begin errors++; $display("FAIL shr_flags: got %b expected 0100", flags); end
    step();
    drive(1'b0, mk(6, 0, 0, 1, 14, 0, 1), 4'h0, 4'b1001);
    checks++; if (flags !== 4'b0100) begin errors++; $display("FAIL shl_flags: got %b expected 0100", flags); end
    step();
    drive(1'b0, mk(5, 0, 0, 1, 14, 0, 0), 4'h0, 4'b1001);
    step();
    drive(1'b0, mk(0, 4, 0, 0, 0, 0, 0), 4'h0, 4'h0);
    checks++; if (adr_out !== 4'b0100) begin errors++; $display("FAIL shr_r4: got %b expected 0100", adr_out); end
    drive(1'b0, mk(0, 6, 0, 0, 0, 0, 0), 4'h0, 4'h0);
    checks++; if (adr_out !== 4'b0010) begin errors++; $display("FAIL shl_r6: got %b expected 0010", adr_out); end
    drive(1'b0, mk(0, 5, 0, 0, 0, 0, 0), 4'h0, 4'h0);
    checks++; if (adr_out !== 4'b1010) begin errors++; $display("FAIL rw0_r5_kept: got %b expected 1010", adr_out); end
  endtask

  task automatic test_all_fs();
    int exp_f  [16] = '{7, 8, 8, 9, 5, 6, 6, 7, 1, 7, 6, 8, 1, 0, 2, 1};
    int exp_fl [16] = '{0, 10, 10, 10, 4, 4, 4, 0, 0, 0, 0, 2, 0, 5, 0, 0};
    drive(1'b0, mk(1, 0, 0, 0, 0, 1, 1), 4'b0111, 4'h0);
    step();
    drive(1'b0, mk(2, 0, 0, 0, 0, 1, 1), 4'b0001, 4'h0);
    step();
    for (int fs = 0; fs < 16; fs++) begin
      drive(1'b0, mk(3, 1, 2, 0, fs, 0, 1), 4'h0, 4'h0);
      checks++; if (flags !== 4'(exp_fl[fs])) begin errors++; $display("FAIL fs%0d_flags: got %b expected %b", fs, flags, 4'(exp_fl[fs])); end
      step();
      drive(1'b0, mk(0, 3, 0, 0, 0, 0, 0), 4'h0, 4'h0);
      checks++; if (adr_out !== 4'(exp_f[fs])) begin errors++; $display("FAIL fs%0d_result: got %b expected %b", fs, adr_out, 4'(exp_f[fs])); end
    end
  endtask

  task automatic test_read_during_write();
    // R4 holds 0100 from the shift test
    drive(1'b0, mk(4, 4, 0, 0, 0, 1, 1), 4'b1100, 4'h0);
    checks++; if (adr_out !== 4'b0100) begin errors++; $display("FAIL rdw_before_edge: got %b expected 0100", adr_out); end
    step();
    checks++; if (adr_out !== 4'b1100) begin errors++; $display("FAIL rdw_after_edge: got %b expected 1100", adr_out); end
  endtask

  task automatic test_reset_discards_write();
    for (int i = 0; i < 8; i++) begin
      drive(1'b0, mk(i, 0, 0, 0, 0, 1, 1), 4'(i + 3), 4'h0);
      step();
    end
    drive(1'b0, mk(0, 7, 0, 0, 0, 0, 0), 4'h0, 4'h0);
    checks++; if (adr_out !== 4'b1010) begin errors++; $display("FAIL prefill_r7: got %b expected 1010", adr_out); end
    drive(1'b1, mk(5, 0, 0, 0, 0, 1, 1), 4'hF, 4'h0);
    step();
    for (int i = 0; i < 8; i++) begin
      drive(1'b0, mk(0, i, 0, 0, 0, 0, 0), 4'h0, 4'h0);
      checks++; if (adr_out !== 4'b0000) begin errors++; $display("FAIL rst_clear R%0d: got %b expected 0000", i, adr_out); end
    end
  endtask

  task automatic test_random();
    logic [15:0] c;
    logic [3:0]  di, k;
    logic        r;
    int a, b, f, fl;
    for (int n = 0; n < 300; n++) begin
      c  = 16'($urandom);
      di = 4'($urandom);
      k  = 4'($urandom);
      r  = ($urandom_range(0, 19) == 0);
      drive(r, c, di, k);
      a = mreg[c[12:10]];
      b = c[6] ? int'(k) : mreg[c[9:7]];
      ref_alu(int'(c[5:2]), a, b, f, fl);
      checks++; if (adr_out !== 4'(a)) begin errors++; $display("FAIL rnd%0d_adr_out: got %b expected %b", n, adr_out, 4'(a)); end
      checks++; if (dataout !== 4'(b)) begin errors++; $display("FAIL rnd%0d_dataout: got %b expected %b", n, dataout, 4'(b)); end
      checks++; if (flags !== 4'(fl)) begin errors++; $display("FAIL rnd%0d_flags fs=%b: got %b expected %b", n, c[5:2], flags, 4'(fl)); end
      step();
    end
    for (int i = 0; i < 8; i++) begin
      drive(1'b0, mk(0, i, 0, 0, 0, 0, 0), 4'h0, 4'h0);
      checks++; if (adr_out !== 4'(mreg[i])) begin errors++; $display("FAIL rnd_final R%0d: got %b expected %b", i, adr_out, 4'(mreg[i])); end
    end
  endtask

  initial begin
    for (int i = 0; i < 8; i++) mreg[i] = 0;
    rst = 1'b1; control = '0; datain = '0; Constant_IN = '0;
    test_reset();
    test_load();
    test_add_const();
    test_sub();
    test_shift();
    test_all_fs();
    test_read_during_write();
    test_reset_discards_write();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
